// File: rtl/seckey_lfsr_resp_if.sv
// Bus-side bundle for the security-key responder.
// Host drives the access qualifiers; the responder drives the SDRD pad and status.
interface seckey_lfsr_resp_if;
  logic        acc;
  logic        sel_n;
  logic [13:0] ba;
  logic        br_w;
  logic        sdrd;
  logic        sdrd_oe;
  logic        locked;
  logic [3:0]  hunt_idx;

  modport master (
    output acc, sel_n, ba, br_w,
    input  sdrd, sdrd_oe, locked, hunt_idx
  );

  modport slave (
    input  acc, sel_n, ba, br_w,
    output sdrd, sdrd_oe, locked, hunt_idx
  );
endinterface

// File: rtl/seckey_lfsr_resp.sv
// Security-key responder: nibble unlock hunt, then LFSR response bit per read.
// Optional SECKEY_AUTORELOCK_EN relocks after MAX_BITS reads.
module seckey_lfsr_resp #(
  parameter int              LFSR_W     = 6,
  parameter logic [LFSR_W-1:0] TAPS     = 6'h30,
  parameter logic [LFSR_W-1:0] SEED     = 6'h2D,
  parameter logic [LFSR_W-1:0] OUT_MASK = 6'h29,
  parameter int              UNLOCK_LEN = 4,
  parameter logic [63:0]     UNLOCK_SEQ = 64'h52A5,
  parameter logic [1:0]      WIN        = 2'b01
`ifdef SECKEY_AUTORELOCK_EN
  ,
  parameter int              MAX_BITS   = 64
`endif
) (
  input logic               clk,
  input logic               rst,
  seckey_lfsr_resp_if.slave bus
);

  typedef enum logic {
    S_LOCKED,
    S_UNLOCKED
  } state_t;

  state_t            r_state;
  state_t            w_state_nx;
  logic [LFSR_W-1:0] r_lfsr;
  logic [LFSR_W-1:0] w_lfsr_pre;
  logic [LFSR_W-1:0] w_lfsr_nx;
  logic [LFSR_W-1:0] w_shift;
  logic [LFSR_W-1:0] w_mix;
  logic [3:0]        r_idx;
  logic [3:0]        w_idx_nx;
  logic [3:0]        w_nib;
  logic [4:0]        w_idx_inc;
  logic              w_qual;
  logic              w_rd;
  logic              w_wr;

`ifdef SECKEY_AUTORELOCK_EN
  localparam int CNT_W = $clog2(MAX_BITS + 1);
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nx;
`endif

  function automatic logic [3:0] seq_at(input logic [3:0] i);
    return UNLOCK_SEQ[4*(UNLOCK_LEN-1-int'(i)) +: 4];
  endfunction

  assign w_qual    = bus.acc & ~bus.sel_n
                   & (bus.ba[13:12] == WIN);
  assign w_rd      = w_qual & bus.br_w;
  assign w_wr      = w_qual & ~bus.br_w;
  assign w_nib     = bus.ba[7:4];
  assign w_idx_inc = {1'b0, r_idx} + 5'd1;
  assign w_shift   = {r_lfsr[LFSR_W-2:0],
                      ^(r_lfsr & TAPS)};

  always_comb begin
    w_mix      = r_lfsr;
    w_mix[3:0] = r_lfsr[3:0] ^ w_nib;
  end

  always_comb begin
    w_state_nx = r_state;
    w_idx_nx   = r_idx;
    w_lfsr_pre = r_lfsr;
`ifdef SECKEY_AUTORELOCK_EN
    w_cnt_nx   = r_cnt;
`endif
    unique case (r_state)
      S_LOCKED: begin
        if (w_rd) begin
          if (w_nib == seq_at(r_idx)) begin
            if (w_idx_inc == 5'(UNLOCK_LEN)) begin
              w_state_nx = S_UNLOCKED;
              w_idx_nx   = 4'd0;
              w_lfsr_pre = SEED;
`ifdef SECKEY_AUTORELOCK_EN
              w_cnt_nx   = '0;
`endif
            end else begin
              w_idx_nx = w_idx_inc[3:0];
            end
          end else begin
            // a mismatching nibble may itself start a new attempt
            w_idx_nx = (w_nib == seq_at(4'd0)) ? 4'd1 : 4'd0;
          end
        end else if (w_wr) begin
          w_idx_nx = 4'd0;
        end
      end
      S_UNLOCKED: begin
        if (w_rd) begin
          w_lfsr_pre = w_shift;
`ifdef SECKEY_AUTORELOCK_EN
          w_cnt_nx = r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(MAX_BITS - 1)) begin
            w_state_nx = S_LOCKED;
            w_idx_nx   = 4'd0;
          end
`endif
        end else if (w_wr) begin
          if (w_nib == 4'hF) begin
            w_state_nx = S_LOCKED;
            w_idx_nx   = 4'd0;
          end else begin
            w_lfsr_pre = w_mix;
          end
        end
      end
      default: ;
    endcase
    w_lfsr_nx = (w_lfsr_pre == '0) ? SEED : w_lfsr_pre;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_LOCKED;
      r_idx   <= 4'd0;
      r_lfsr  <= SEED;
`ifdef SECKEY_AUTORELOCK_EN
      r_cnt   <= '0;
`endif
    end else begin
      r_state <= w_state_nx;
      r_idx   <= w_idx_nx;
      r_lfsr  <= w_lfsr_nx;
`ifdef SECKEY_AUTORELOCK_EN
      r_cnt   <= w_cnt_nx;
`endif
    end
  end

  assign bus.sdrd_oe  = w_rd & ~rst
                      & (r_state == S_UNLOCKED);
  assign bus.sdrd     = bus.sdrd_oe
                      & (^(r_lfsr & OUT_MASK));
  assign bus.locked   = (r_state == S_LOCKED);
  assign bus.hunt_idx = r_idx;

endmodule

// File: tb/tb_seckey_lfsr_resp.sv
// Scoreboard bench for seckey_lfsr_resp.
// Expected sdrd/oe pushed per access, popped and checked in each test.
module tb_seckey_lfsr_resp;

  localparam logic [5:0]  SEED = 6'h2D;
  localparam logic [15:0] SEQ  = 16'h52A5;

  typedef struct {
    logic oe;
    logic d;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seckey_lfsr_resp_if bus();

  seckey_lfsr_resp dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int         n_chk  = 0;
  int         n_fail = 0;
  exp_t       sb[$];
  logic       m_locked = 1'b1;
  logic [3:0] m_idx    = 4'd0;
  logic [5:0] m_lfsr   = SEED;
  int         m_cnt    = 0;

  function automatic logic [3:0] seqn(input int i);
    logic [15:0] s;
    s = SEQ;
    return s[4*(3-i) +: 4];
  endfunction

  task automatic cyc(input logic r, input logic a,
                     input logic s_n, input logic [1:0] w,
                     input logic rd, input logic [3:0] nib,
                     output logic [1:0] resp);
    exp_t e;
    logic q;
    @(negedge clk);
    rst       = r;
    bus.acc   = a;
    bus.sel_n = s_n;
    bus.ba    = {w, 4'h0, nib, 4'h0};
    bus.br_w  = rd;
    q    = a && !s_n && (w == 2'b01);
    e.oe = q && rd && !m_locked && !r;
    e.d  = e.oe && (^(m_lfsr & 6'h29));
    sb.push_back(e);
    #1;
    resp = {bus.sdrd_oe, bus.sdrd};
    if (r) begin
      m_locked = 1'b1; m_idx = 4'd0;
      m_lfsr = SEED; m_cnt = 0;
    end else if (q) begin
      if (m_locked) begin
        if (!rd) m_idx = 4'd0;
        else if (nib == seqn(int'(m_idx))) begin
          if (int'(m_idx) + 1 == 4) begin
            m_locked = 1'b0; m_idx = 4'd0;
            m_lfsr = SEED; m_cnt = 0;
          end else m_idx = m_idx + 4'd1;
        end else m_idx = (nib == 4'h5) ? 4'd1 : 4'd0;
      end else if (rd) begin
        m_lfsr = {m_lfsr[4:0], m_lfsr[5] ^ m_lfsr[4]};
        m_cnt++;
`ifdef SECKEY_AUTORELOCK_EN
        if (m_cnt == 64) m_locked = 1'b1;
`endif
      end else if (nib == 4'hF) begin
        m_locked = 1'b1; m_idx = 4'd0;
      end else m_lfsr[3:0] = m_lfsr[3:0] ^ nib;
      if (m_lfsr == 6'h0) m_lfsr = SEED;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic rd_(input logic [3:0] nib, output logic [1:0] resp);
    cyc(1'b0, 1'b1, 1'b0, 2'b01, 1'b1, nib, resp);
  endtask

  task automatic wr_(input logic [3:0] nib, output logic [1:0] resp);
    cyc(1'b0, 1'b1, 1'b0, 2'b01, 1'b0, nib, resp);
  endtask

  task automatic do_reset();
    logic [1:0] r;
    cyc(1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 4'h0, r);
    rst = 1'b0;
    sb.delete();
  endtask

  task automatic unlock();
    logic [1:0] r;
    for (int i = 0; i < 4; i++) rd_(seqn(i), r);
    sb.delete();
  endtask

  task automatic test_reset();
    logic [1:0] r;
    exp_t e;
    do_reset();
    n_chk++;
    if (bus.locked !== 1'b1 || bus.hunt_idx !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_state: got %b/%h want 1/0", bus.locked, bus.hunt_idx);
    end
    rd_(4'h0, r);
    e = sb.pop_front();
    n_chk++;
    if (r !== 2'b00 || r !== {e.oe, e.d}) begin
      n_fail++;
      $display("FAIL reset_resp: got %b want 00", r);
    end
  endtask

  task automatic test_unlock();
    logic [1:0] r;
    logic       c[3] = '{1'b1, 1'b0, 1'b0};
    exp_t       e;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      rd_(seqn(i), r);
      void'(sb.pop_front());
      n_chk++;
      if (bus.locked !== (i < 3) || bus.hunt_idx !== m_idx) begin
        n_fail++;
        $display("FAIL unlock_step%0d: got %b/%h want %b/%h",
                 i, bus.locked, bus.hunt_idx, i < 3, m_idx);
      end
    end
    for (int i = 0; i < 3; i++) begin
      rd_(4'h0, r);
      e = sb.pop_front();
      n_chk++;
      if (r !== {1'b1, c[i]} || r !== {e.oe, e.d}) begin
        n_fail++;
        $display("FAIL unlock_bit%0d: got %b want %b", i, r, {1'b1, c[i]});
      end
    end
  endtask

  task automatic test_restart();
    logic [1:0] r;
    logic [3:0] a[5] = '{4'h5, 4'h5, 4'h2, 4'hA, 4'h5};
    logic [3:0] b[7] = '{4'h5, 4'h2, 4'h3, 4'h5, 4'h2, 4'hA, 4'h5};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      rd_(a[i], r);
      void'(sb.pop_front());
      n_chk++;
      if (bus.locked !== (i < 4) || bus.hunt_idx !== m_idx) begin
        n_fail++;
        $display("FAIL restart_a%0d: got %b/%h want %b/%h",
                 i, bus.locked, bus.hunt_idx, i < 4, m_idx);
      end
    end
    do_reset();
    for (int i = 0; i < 7; i++) begin
      rd_(b[i], r);
      void'(sb.pop_front());
      n_chk++;
      if (bus.locked !== (i < 6) || bus.hunt_idx !== m_idx) begin
        n_fail++;
        $display("FAIL restart_b%0d: got %b/%h want %b/%h",
                 i, bus.locked, bus.hunt_idx, i < 6, m_idx);
      end
    end
  endtask

  task automatic test_challenge();
    logic [1:0] r;
    exp_t e;
    do_reset();
    unlock();
    wr_(4'hD, r);
    void'(sb.pop_front());
    for (int i = 0; i < 4; i++) begin
      rd_(4'h0, r);
      e = sb.pop_front();
      n_chk++;
      if (r !== {e.oe, e.d} || (i == 0 && r !== 2'b11)) begin
        n_fail++;
        $display("FAIL challenge_rd%0d: got %b want %b", i, r, {e.oe, e.d});
      end
    end
    wr_(4'hF, r);
    void'(sb.pop_front());
    n_chk++;
    if (bus.locked !== 1'b1) begin
      n_fail++;
      $display("FAIL relock: got %b want 1", bus.locked);
    end
    for (int i = 0; i < 3; i++) begin
      rd_(4'h0, r);
      void'(sb.pop_front());
      n_chk++;
      if (r !== 2'b00) begin
        n_fail++;
        $display("FAIL relock_rd%0d: got %b want 00", i, r);
      end
    end
  endtask

  task automatic test_zero_guard();
    logic [1:0] r;
    logic       c[2] = '{1'b1, 1'b0};
    exp_t e;
    do_reset();
    unlock();
    wr_(4'h0, r);
    void'(sb.pop_front());
    rd_(4'h0, r);
    e = sb.pop_front();
    n_chk++;
    if (r !== 2'b11 || r !== {e.oe, e.d}) begin
      n_fail++;
      $display("FAIL nop_write: got %b want 11", r);
    end
    for (int i = 0; i < 70; i++) begin
      if (m_lfsr[5:4] == 2'b00 && m_lfsr[3:0] != 4'h5) break;
      rd_(4'h0, r);
      void'(sb.pop_front());
    end
    wr_(m_lfsr[3:0] ^ 4'hA, r);
    void'(sb.pop_front());
    n_chk++;
    if (m_lfsr !== 6'h0A || bus.locked !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_setup: got %b want 0 (lfsr %h)", bus.locked, m_lfsr);
    end
    wr_(4'hA, r);
    void'(sb.pop_front());
    for (int i = 0; i < 2; i++) begin
      rd_(4'h0, r);
      e = sb.pop_front();
      n_chk++;
      if (r !== {1'b1, c[i]} || r !== {e.oe, e.d}) begin
        n_fail++;
        $display("FAIL zero_guard%0d: got %b want %b", i, r, {1'b1, c[i]});
      end
    end
  endtask

  task automatic test_unqualified();
    logic [1:0] r;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 4; i++) begin
        cyc(1'b0, k != 2, k == 0, (k == 1) ? 2'b10 : 2'b01,
            1'b1, seqn(i), r);
        void'(sb.pop_front());
        n_chk++;
        if (bus.locked !== 1'b1 || bus.hunt_idx !== 4'd0 || r !== 2'b00) begin
          n_fail++;
          $display("FAIL unqual_k%0d_%0d: got %b/%h/%b want 1/0/00",
                   k, i, bus.locked, bus.hunt_idx, r);
        end
      end
    end
    unlock();
    cyc(1'b0, 1'b1, 1'b1, 2'b01, 1'b1, 4'h0, r);
    void'(sb.pop_front());
    cyc(1'b0, 1'b1, 1'b0, 2'b11, 1'b0, 4'hF, r);
    void'(sb.pop_front());
    rd_(4'h0, r);
    void'(sb.pop_front());
    n_chk++;
    if (r !== 2'b11 || bus.locked !== 1'b0) begin
      n_fail++;
      $display("FAIL unqual_unlocked: got %b/%b want 11/0", r, bus.locked);
    end
  endtask

  task automatic test_rst_priority();
    logic [1:0] r;
    do_reset();
    for (int i = 0; i < 3; i++) rd_(seqn(i), r);
    cyc(1'b1, 1'b1, 1'b0, 2'b01, 1'b1, 4'h5, r);
    rst = 1'b0;
    sb.delete();
    n_chk++;
    if (bus.locked !== 1'b1 || bus.hunt_idx !== 4'd0 || r !== 2'b00) begin
      n_fail++;
      $display("FAIL rst_prio: got %b/%h/%b want 1/0/00",
               bus.locked, bus.hunt_idx, r);
    end
    unlock();
    rd_(4'h0, r);
    rd_(4'h0, r);
    do_reset();
    unlock();
    rd_(4'h0, r);
    void'(sb.pop_front());
    n_chk++;
    if (r !== 2'b11) begin
      n_fail++;
      $display("FAIL rst_midstream: got %b want 11", r);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] r;
    logic [3:0] nib;
    logic       rd;
    int         bad = 0;
    exp_t       e;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      rd  = ($urandom_range(0, 9) < 7);
      nib = 4'($urandom_range(0, 15));
      if (rd && m_locked && $urandom_range(0, 3) != 0)
        nib = seqn(int'(m_idx));
      if (!rd && !m_locked && $urandom_range(0, 5) != 0 && nib == 4'hF)
        nib = 4'h3;
      cyc(1'b0, 1'b1, 1'b0, 2'b01, rd, nib, r);
      e = sb.pop_front();
      n_chk++;
      if (r !== {e.oe, e.d} || bus.locked !== m_locked
          || bus.hunt_idx !== m_idx) begin
        n_fail++;
        bad++;
        if (bad < 5)
          $display("FAIL b2b_%0d: got %b/%b/%h want %b/%b/%h", i,
                   r, bus.locked, bus.hunt_idx, {e.oe, e.d}, m_locked, m_idx);
      end
    end
  endtask

  task automatic test_autorelock();
    logic [1:0] r;
    logic       ar;
    exp_t       e;
`ifdef SECKEY_AUTORELOCK_EN
    ar = 1'b1;
`else
    ar = 1'b0;
`endif
    do_reset();
    unlock();
    for (int i = 0; i < 64; i++) begin
      rd_(4'h0, r);
      e = sb.pop_front();
      n_chk++;
      if (r[1] !== 1'b1 || r !== {e.oe, e.d}
          || bus.locked !== (ar && i == 63)) begin
        n_fail++;
        $display("FAIL autorelock_rd%0d: got %b/%b want %b/%b",
                 i, r, bus.locked, {e.oe, e.d}, ar && i == 63);
      end
    end
    rd_(4'h0, r);
    void'(sb.pop_front());
    n_chk++;
    if (r[1] !== !ar) begin
      n_fail++;
      $display("FAIL autorelock_65: got oe %b want %b", r[1], !ar);
    end
  endtask

  initial begin
    bus.acc   = 1'b0;
    bus.sel_n = 1'b1;
    bus.ba    = 14'h0;
    bus.br_w  = 1'b0;
    test_reset();
    test_unlock();
    test_restart();
    test_challenge();
    test_zero_guard();
    test_unqualified();
    test_rst_priority();
    test_back_to_back();
    test_autorelock();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
